qspi_sram_controller: RTL

Single-requester QSPI SRAM master that turns byte read/write requests into SPI transactions on the external QSPI SRAM. It issues quad read 0xEB (1S-4S-4S, dummy cycles) and quad write 0x38 (1S-4S-4S), generates `sck` at clk/2, and returns read bytes through a one-cycle response pulse. It sits between the design's memory client and the chip-level QSPI pads.

---
 rtl/qspi_sram_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/qspi_sram_controller.sv
// Purpose: single-requester QSPI SRAM master (quad read 0xEB, quad write 0x38, sck = clk/2).
// Latency: accept at E0, read response in cycle after E(2*(16+WAIT_CYCLES)), write response in cycle after E32.
// Backpressure: req_ready is high only in IDLE; requests offered while busy are ignored until IDLE.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accept on req_valid && req_ready)
//   req_we/req_addr/req_wdata  request payload, latched on accept
//   rsp_valid/rsp_rdata      one-cycle completion pulse, read byte (held until next read completes)
//   sck, ss_n                SPI clock (idle low) and chip select (active low)
//   sio_in/sio_out/sio_oe    quad data lines from/to pads and per-line output enables

module qspi_sram_controller #(
  parameter logic [7:0] CMD_READ    = 8'hEB,
  parameter logic [7:0] CMD_WRITE   = 8'h38,
  parameter int         WAIT_CYCLES = 4       // dummy beats before read data, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        sck,
  output logic        ss_n,
  input  logic [3:0]  sio_in,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_WDATA = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Index of the final beat in each serial state.
  localparam logic [3:0] CMD_LAST  = 4'd7;
  localparam logic [3:0] ADDR_LAST = 4'd5;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] DATA_LAST = 4'd1;

  logic [2:0]  state;
  logic [2:0]  next_serial;
  logic        phase;        // 0 = sck low half of a beat, 1 = sck high half
  logic [3:0]  beat_cnt;
  logic        last_beat;
  logic        serial_active;
  logic [7:0]  cmd_sr;
  logic [23:0] addr_sr;
  logic [7:0]  wdata_sr;
  logic        we_q;
  logic [3:0]  rdata_hi;     // first (upper) read nibble, parked until the second arrives

  assign serial_active = (state == ST_CMD)  || (state == ST_ADDR)  || (state == ST_WAIT) ||
                         (state == ST_RDATA) || (state == ST_WDATA);

  // Interface outputs are decoded straight from state registers so that an
  // asynchronous reset takes the pads to idle in the same cycle.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign ss_n      = ~serial_active;
  assign sck       = serial_active & phase;

  always_comb begin
    sio_out = 4'b0000;
    sio_oe  = 4'b0000;
    case (state)
      ST_CMD: begin
        sio_out = {3'b000, cmd_sr[7]};
        sio_oe  = 4'b0001;
      end
      ST_ADDR: begin
        sio_out = addr_sr[23:20];
        sio_oe  = 4'b1111;
      end
      ST_WDATA: begin
        sio_out = wdata_sr[7:4];
        sio_oe  = 4'b1111;
      end
      default: ;  // WAIT/RDATA turn the bus around; IDLE/DONE leave it released
    endcase
  end

  always_comb begin
    last_beat = 1'b0;
    case (state)
      ST_CMD:             last_beat = (beat_cnt == CMD_LAST);
      ST_ADDR:            last_beat = (beat_cnt == ADDR_LAST);
      ST_WAIT:            last_beat = (beat_cnt == WAIT_LAST);
      ST_RDATA, ST_WDATA: last_beat = (beat_cnt == DATA_LAST);
      default:            last_beat = 1'b0;
    endcase
  end

  always_comb begin
    next_serial = ST_DONE;
    case (state)
      ST_CMD:  next_serial = ST_ADDR;
      ST_ADDR: next_serial = we_q ? ST_WDATA : ST_WAIT;
      ST_WAIT: next_serial = ST_RDATA;
      default: next_serial = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      beat_cnt  <= 4'd0;
      cmd_sr    <= 8'h00;
      addr_sr   <= 24'h000000;
      wdata_sr  <= 8'h00;
      we_q      <= 1'b0;
      rdata_hi  <= 4'h0;
      rsp_rdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state    <= ST_CMD;
            phase    <= 1'b0;
            beat_cnt <= 4'd0;
            cmd_sr   <= req_we ? CMD_WRITE : CMD_READ;
            addr_sr  <= req_addr;
            wdata_sr <= req_wdata;
            we_q     <= req_we;
          end
        end

        ST_CMD, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA: begin
          phase <= ~phase;
          // The edge that ends the high half closes the beat: the SRAM has
          // sampled our data, so advance the shifters, and its read data is
          // stable, so capture sio_in here.
          if (phase) begin
            beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
            case (state)
              ST_CMD:   cmd_sr   <= {cmd_sr[6:0], 1'b0};
              ST_ADDR:  addr_sr  <= {addr_sr[19:0], 4'h0};
              ST_WDATA: wdata_sr <= {wdata_sr[3:0], 4'h0};
              ST_RDATA: begin
                if (beat_cnt == 4'd0) rdata_hi <= sio_in;
                else                  rsp_rdata <= {rdata_hi, sio_in};
              end
              default: ;
            endcase
            if (last_beat) state <= next_serial;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;  // unused encoding recovers to idle
      endcase
    end
  end

endmodule
